// File: rtl/scr1_cg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_cg_ctrl_pkg
//  Description : Shared types and default delays for the core clock-gate
//                sleep/wake sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package scr1_cg_ctrl_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      RUN       = 3'd0,
      DRAIN     = 3'd1,
      IDLE_WAIT = 3'd2,
      SLEEP     = 3'd3,
      WAKE      = 3'd4
   } type_scr1_cg_ctrl_state_e;

   localparam int SCR1_CG_CTRL_IDLE_DLY_DFLT = 4;
   localparam int SCR1_CG_CTRL_WAKE_DLY_DFLT = 2;

endpackage : scr1_cg_ctrl_pkg
`default_nettype wire

// File: rtl/scr1_cg_ctrl_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_cg_ctrl_cnt
//  Description : Loadable down-counter with zero flag, shared by the idle
//                delay and the wake settle delay. Never wraps below zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_cg_ctrl_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Load has priority; decrement only while nonzero so the count saturates at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule : scr1_cg_ctrl_cnt
`default_nettype wire

// File: rtl/scr1_cg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_cg_ctrl
//  Description : Sleep/wake sequencer driving the core clock-gate enable.
//                Drains the pipeline, waits an idle delay, gates the clock,
//                and on wake restores the clock and waits for it to settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_cg_ctrl
   import scr1_cg_ctrl_pkg::*;
#(
   parameter int IDLE_DLY = SCR1_CG_CTRL_IDLE_DLY_DFLT,
   parameter int WAKE_DLY = SCR1_CG_CTRL_WAKE_DLY_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sleep_req,
   input  logic pipe_idle,
   input  logic irq_pending,
   input  logic dbg_req,
   input  logic force_on,
   output logic clk_en,
   output logic sleep_ack,
   output logic sleep_abort,
   output logic wake_done
);

   // Counter sized for the larger of the two delays
   localparam int c_max_dly = (IDLE_DLY > WAKE_DLY) ? IDLE_DLY : WAKE_DLY;
   localparam int CNT_W     = (c_max_dly < 1) ? 1 : $clog2(c_max_dly + 1);

   localparam logic [CNT_W-1:0] c_idle_load = (IDLE_DLY > 0) ? CNT_W'(IDLE_DLY - 1) : '0;
   localparam logic [CNT_W-1:0] c_wake_load = (WAKE_DLY > 0) ? CNT_W'(WAKE_DLY - 1) : '0;

   type_scr1_cg_ctrl_state_e r_state;
   type_scr1_cg_ctrl_state_e w_state_nxt;

   logic             w_wake;
   logic             w_cnt_load;
   logic [CNT_W-1:0] w_cnt_load_val;
   logic             w_cnt_dec;
   logic             w_cnt_zero;
   logic             w_abort_nxt;
   logic             w_done_nxt;

   logic r_clk_en;
   logic r_sleep_ack;
   logic r_sleep_abort;
   logic r_wake_done;

   // clk is never gated, so wake sources are always observed here
   assign w_wake = irq_pending | dbg_req | force_on;

   scr1_cg_ctrl_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, counter control and pulse decisions; wake beats any sleep step
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = '0;
      w_cnt_dec      = 1'b0;
      w_abort_nxt    = 1'b0;
      w_done_nxt     = 1'b0;
      case (r_state)
         RUN: begin
            if (sleep_req && !w_wake) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_wake || !sleep_req) begin
               w_state_nxt = RUN;
               w_abort_nxt = 1'b1;
            end else if (pipe_idle) begin
               if (IDLE_DLY == 0) begin
                  w_state_nxt = SLEEP;
               end else begin
                  w_state_nxt    = IDLE_WAIT;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = c_idle_load;
               end
            end
         end
         IDLE_WAIT: begin
            if (w_wake || !sleep_req) begin
               w_state_nxt = RUN;
               w_abort_nxt = 1'b1;
            end else if (!pipe_idle) begin
               w_state_nxt = DRAIN;
            end else if (w_cnt_zero) begin
               w_state_nxt = SLEEP;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         SLEEP: begin
            // sleep_req is meaningless here: the core is frozen
            if (w_wake) begin
               w_state_nxt    = WAKE;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = c_wake_load;
            end
         end
         WAKE: begin
            if (w_cnt_zero) begin
               w_state_nxt = RUN;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   // Registered outputs follow the next state so clk_en only moves on clk edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_en      <= 1'b1;
         r_sleep_ack   <= 1'b0;
         r_sleep_abort <= 1'b0;
         r_wake_done   <= 1'b0;
      end else begin
         r_clk_en      <= (w_state_nxt != SLEEP);
         r_sleep_ack   <= (w_state_nxt == SLEEP);
         r_sleep_abort <= w_abort_nxt;
         r_wake_done   <= w_done_nxt;
      end
   end

   assign clk_en      = r_clk_en;
   assign sleep_ack   = r_sleep_ack;
   assign sleep_abort = r_sleep_abort;
   assign wake_done   = r_wake_done;

endmodule : scr1_cg_ctrl
`default_nettype wire

// File: tb/tb_scr1_cg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scr1_cg_ctrl
//  Description : Self-checking bench for scr1_cg_ctrl. Two instances
//                (IDLE_DLY=4 and IDLE_DLY=0, WAKE_DLY=2) share stimulus and
//                are compared each cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_cg_ctrl;

   localparam int WAKE_DLY = 2;

   logic clk;
   logic rst_n;
   logic sleep_req;
   logic pipe_idle;
   logic irq_pending;
   logic dbg_req;
   logic force_on;

   logic [1:0] clk_en_v;
   logic [1:0] sleep_ack_v;
   logic [1:0] sleep_abort_v;
   logic [1:0] wake_done_v;

   int n_chk = 0;
   int n_err = 0;

   // Model: phase of each instance and the figures that drive it
   localparam int P_RUN    = 0;
   localparam int P_ARM    = 1;
   localparam int P_GATED  = 2;
   localparam int P_WAKING = 3;

   int m_idle  [2];
   int m_phase [2];
   int m_run   [2];
   int m_wcnt  [2];
   int m_abort [2];
   int m_done  [2];

   scr1_cg_ctrl #(
      .IDLE_DLY (4),
      .WAKE_DLY (WAKE_DLY)
   ) u_dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .sleep_req   (sleep_req),
      .pipe_idle   (pipe_idle),
      .irq_pending (irq_pending),
      .dbg_req     (dbg_req),
      .force_on    (force_on),
      .clk_en      (clk_en_v[0]),
      .sleep_ack   (sleep_ack_v[0]),
      .sleep_abort (sleep_abort_v[0]),
      .wake_done   (wake_done_v[0])
   );

   scr1_cg_ctrl #(
      .IDLE_DLY (0),
      .WAKE_DLY (WAKE_DLY)
   ) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .sleep_req   (sleep_req),
      .pipe_idle   (pipe_idle),
      .irq_pending (irq_pending),
      .dbg_req     (dbg_req),
      .force_on    (force_on),
      .clk_en      (clk_en_v[1]),
      .sleep_ack   (sleep_ack_v[1]),
      .sleep_abort (sleep_abort_v[1]),
      .wake_done   (wake_done_v[1])
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = P_RUN;
         m_run[i]   = 0;
         m_wcnt[i]  = 0;
         m_abort[i] = 0;
         m_done[i]  = 0;
      end
   endtask

   // Arming counts consecutive idle cycles after the request is accepted;
   // the clock gates once the count reaches IDLE_DLY+1.
   task automatic model_update();
      bit wk;
      wk = irq_pending | dbg_req | force_on;
      for (int i = 0; i < 2; i++) begin
         m_abort[i] = 0;
         m_done[i]  = 0;
         case (m_phase[i])
            P_RUN: begin
               if (sleep_req && !wk) begin
                  m_phase[i] = P_ARM;
                  m_run[i]   = 0;
               end
            end
            P_ARM: begin
               if (wk || !sleep_req) begin
                  m_phase[i] = P_RUN;
                  m_abort[i] = 1;
               end else if (pipe_idle) begin
                  m_run[i]++;
                  if (m_run[i] == m_idle[i] + 1) m_phase[i] = P_GATED;
               end else begin
                  m_run[i] = 0;
               end
            end
            P_GATED: begin
               if (wk) begin
                  m_phase[i] = P_WAKING;
                  m_wcnt[i]  = 0;
               end
            end
            default: begin
               m_wcnt[i]++;
               if (m_wcnt[i] == WAKE_DLY) begin
                  m_phase[i] = P_RUN;
                  m_done[i]  = 1;
               end
            end
         endcase
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("clk_en[%0d]", i),      int'(clk_en_v[i]),      (m_phase[i] != P_GATED) ? 1 : 0);
         check($sformatf("sleep_ack[%0d]", i),   int'(sleep_ack_v[i]),   (m_phase[i] == P_GATED) ? 1 : 0);
         check($sformatf("sleep_abort[%0d]", i), int'(sleep_abort_v[i]), m_abort[i]);
         check($sformatf("wake_done[%0d]", i),   int'(wake_done_v[i]),   m_done[i]);
      end
   endtask

   // One clock: inputs already set, advance model with them, sample 1 after edge
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic set_in(input bit sr, input bit pi, input bit ir, input bit dr, input bit fo);
      sleep_req   = sr;
      pipe_idle   = pi;
      irq_pending = ir;
      dbg_req     = dr;
      force_on    = fo;
   endtask

   // Reset pulse placed between edges; outputs must recover without a clock
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_clk_en0"},    int'(clk_en_v[0]),    1);
      check({tag, "_clk_en1"},    int'(clk_en_v[1]),    1);
      check({tag, "_sleep_ack0"}, int'(sleep_ack_v[0]), 0);
      check({tag, "_sleep_ack1"}, int'(sleep_ack_v[1]), 0);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int lat [2];
      int n;
      m_idle[0] = 4;
      m_idle[1] = 0;
      model_reset();
      set_in(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_clk_en0",    int'(clk_en_v[0]),      1);
      check("rst_sleep_ack0", int'(sleep_ack_v[0]),   0);
      check("rst_abort0",     int'(sleep_abort_v[0]), 0);
      check("rst_done0",      int'(wake_done_v[0]),   0);
      rst_n = 1'b1;
      step();

      // Basic sleep latency with pipeline already idle
      set_in(1, 1, 0, 0, 0);
      lat[0] = -1;
      lat[1] = -1;
      for (int e = 1; e <= 20; e++) begin
         step();
         for (int i = 0; i < 2; i++)
            if (lat[i] < 0 && clk_en_v[i] == 1'b0) lat[i] = e;
      end
      check("sleep_lat_idle4", lat[0], 6);
      check("sleep_lat_idle0", lat[1], 2);

      // Single-cycle debug wake; sleep_req drop is ignored while gated
      set_in(0, 1, 0, 1, 0);
      step();
      check("wake_clk_en0", int'(clk_en_v[0]), 1);
      set_in(0, 1, 0, 0, 0);
      n = 0;
      while (n < 10 && wake_done_v[0] != 1'b1) begin
         step();
         n++;
      end
      check("wake_done_lat", n, WAKE_DLY);
      step();

      // force_on together with sleep_req keeps the block in RUN
      set_in(1, 1, 0, 0, 1);
      repeat (5) step();

      // Drain hold-off, then idle, then gate
      set_in(1, 0, 0, 0, 0);
      repeat (10) step();
      set_in(1, 1, 0, 0, 0);
      repeat (8) step();

      // Reset while both instances are gated
      async_reset("rst_sleep");
      set_in(0, 0, 0, 0, 0);
      repeat (2) step();

      // Interrupt during idle wait aborts; then sleep_req dropped in drain
      set_in(1, 1, 0, 0, 0);
      repeat (3) step();
      set_in(1, 1, 1, 0, 0);
      step();
      set_in(1, 0, 0, 0, 0);
      repeat (2) step();
      set_in(0, 0, 0, 0, 0);
      step();
      set_in(1, 1, 0, 0, 0);
      repeat (3) step();
      set_in(1, 0, 0, 0, 0);
      step();
      set_in(1, 1, 0, 0, 0);
      step();

      // Randomized traffic biased toward reaching the gated state
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(599) == 0) async_reset("rst_rand");
         sleep_req   = ($urandom_range(99) < 93);
         pipe_idle   = ($urandom_range(99) < 85);
         irq_pending = ($urandom_range(99) < 3);
         dbg_req     = ($urandom_range(99) < 2);
         force_on    = ($urandom_range(99) < 2);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_scr1_cg_ctrl
`default_nettype wire
